// File: rtl/opc2x_cpu_if.sv
// opc2x_cpu_if: address/strobe side of the opc2x_cpu memory bus.
// The ready wait-state input exists only when OPC2X_WAIT_EN is defined.
interface opc2x_cpu_if #(parameter int ADDR_W = 11);
  logic [ADDR_W-1:0] address;
  logic rnw;
  logic fetch;
`ifdef OPC2X_WAIT_EN
  logic ready;
  modport master(output address, rnw, fetch, input ready);
  modport slave(input address, rnw, fetch, output ready);
`else
  modport master(output address, rnw, fetch);
  modport slave(input address, rnw, fetch);
`endif
endinterface

// File: rtl/opc2x_cpu.sv
// opc2x_cpu: 8-bit accumulator CPU (OPC-2 ISA) with ADDR_W-bit addressing and opcode fetch strobe.
// Define OPC2X_WAIT_EN to stretch any bus cycle while ready is low.
module opc2x_cpu #(
  parameter int ADDR_W = 11,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h100
) (
  input logic clk,
  input logic reset,
  inout wire [7:0] data,
  opc2x_cpu_if.master bus
);
  localparam int H = ADDR_W - 8;
  localparam logic [3:0] OP_ADC = 4'h0, OP_NOT = 4'h1, OP_AND = 4'h2, OP_AXB = 4'h3,
                         OP_JPC = 4'h4, OP_JPZ = 4'h5, OP_STA = 4'h6, OP_JAL = 4'h7,
                         OP_LDAI = 4'h8, OP_LDA = 4'h9, OP_STAP = 4'hA, OP_LDAP = 4'hC;
  typedef enum logic [2:0] {FETCH0, FETCH1, RDMEM, RDMEM2, EXEC} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] pc, opr;
  logic [7:0] acc, b;
  logic [3:0] ir;
  logic c, go, wr;
`ifdef OPC2X_WAIT_EN
  assign go = bus.ready;
`else
  assign go = 1'b1;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH0;
    else if (go) state <= next;
  always_comb begin
    next = FETCH0;
    case (state)
      FETCH0: next = (data[7] | data[6]) ? FETCH1 : EXEC;
      FETCH1: next = (ir[3] && ir != OP_LDAI) ? RDMEM : EXEC;
      RDMEM: next = ir[2] ? RDMEM2 : EXEC;
      RDMEM2: next = EXEC;
      default: next = FETCH0;
    endcase
  end
  always_comb begin
    wr = state == EXEC && (ir == OP_STA || ir == OP_STAP) && !reset;
    bus.address = (state == RDMEM || state == RDMEM2 || wr) ? opr : pc;
    bus.rnw = !wr;
    bus.fetch = state == FETCH0;
  end
  assign data = wr ? acc : 8'hzz;
  // Loads of every flavour leave their final byte in opr[7:0] before EXEC.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      opr <= '0;
      acc <= '0;
      b <= '0;
      c <= 1'b0;
      ir <= '0;
    end else if (go)
      case (state)
        FETCH0: begin
          ir <= data[7:4];
          opr[ADDR_W-1:8] <= data[H-1:0];
          pc <= pc + ADDR_W'(1);
        end
        FETCH1: begin
          opr[7:0] <= data;
          pc <= pc + ADDR_W'(1);
        end
        RDMEM: opr <= {{H{1'b0}}, data};
        RDMEM2: opr[7:0] <= data;
        EXEC:
          case (ir)
            OP_ADC: {c, acc} <= {1'b0, acc} + {1'b0, b} + {8'h00, c};
            OP_NOT: acc <= ~acc;
            OP_AND: begin
              acc <= acc & b;
              c <= 1'b0;
            end
            OP_AXB: begin
              acc <= b;
              b <= acc;
            end
            OP_JPC: if (c) pc <= opr;
            OP_JPZ: if (acc == 8'h00) pc <= opr;
            OP_JAL: begin
              pc <= {b[H-1:0], acc};
              {b, acc} <= 16'(pc);
            end
            OP_LDAI, OP_LDA, OP_LDAP: acc <= opr[7:0];
            default: ;
          endcase
        default: ;
      endcase
endmodule
